// File: rtl/orb_frame_serializer.sv
// Ping-pong frame reader: prefetches words from the bank released by the filler
// and shifts them out MSB-first, one bit every BIT_DIV clocks.
module orb_frame_serializer #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 10,
  parameter int WORDS   = 1024,
  parameter int BIT_DIV = 40,
  parameter int RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] ramData,
  output logic [ADDR_W:0]   ramAddr,
  output logic              orbSwitch,
  output logic              serData,
  output logic              bitStrobe,
  output logic              wordStrobe,
  output logic              frameSync,
  output logic              busy
);

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CAP_W = $clog2(RD_LAT + 1);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [CAP_W-1:0]  CAP_INIT  = CAP_W'(RD_LAT);
  localparam logic [CAP_W-1:0]  CAP_FIRE  = CAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    divCnt_q, divCnt_d;
  logic [BIT_W-1:0]    bitIdx_q, bitIdx_d;
  logic [ADDR_W-1:0]   wordIdx_q, wordIdx_d;
  logic [CAP_W-1:0]    capCnt_q, capCnt_d;
  logic [DATA_W-1:0]   holdReg_q, holdReg_d;
  logic [DATA_W-1:0]   shiftReg_q, shiftReg_d;
  logic                stop_q, stop_d;
  logic                orbSwitch_q, orbSwitch_d;
  logic [ADDR_W:0]     ramAddr_q, ramAddr_d;
  logic                serData_q, serData_d;
  logic                bitStrobe_q, bitStrobe_d;
  logic                wordStrobe_q, wordStrobe_d;
  logic                frameSync_q, frameSync_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      divCnt_q     <= '0;
      bitIdx_q     <= '0;
      wordIdx_q    <= '0;
      capCnt_q     <= '0;
      holdReg_q    <= '0;
      shiftReg_q   <= '0;
      stop_q       <= 1'b0;
      orbSwitch_q  <= 1'b0;
      ramAddr_q    <= '0;
      serData_q    <= 1'b0;
      bitStrobe_q  <= 1'b0;
      wordStrobe_q <= 1'b0;
      frameSync_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      divCnt_q     <= divCnt_d;
      bitIdx_q     <= bitIdx_d;
      wordIdx_q    <= wordIdx_d;
      capCnt_q     <= capCnt_d;
      holdReg_q    <= holdReg_d;
      shiftReg_q   <= shiftReg_d;
      stop_q       <= stop_d;
      orbSwitch_q  <= orbSwitch_d;
      ramAddr_q    <= ramAddr_d;
      serData_q    <= serData_d;
      bitStrobe_q  <= bitStrobe_d;
      wordStrobe_q <= wordStrobe_d;
      frameSync_q  <= frameSync_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    divCnt_d     = divCnt_q;
    bitIdx_d     = bitIdx_q;
    wordIdx_d    = wordIdx_q;
    capCnt_d     = capCnt_q;
    holdReg_d    = holdReg_q;
    shiftReg_d   = shiftReg_q;
    stop_d       = stop_q;
    orbSwitch_d  = orbSwitch_q;
    ramAddr_d    = ramAddr_q;
    serData_d    = serData_q;
    bitStrobe_d  = 1'b0;
    wordStrobe_d = 1'b0;
    frameSync_d  = 1'b0;

    // Read-latency countdown: capture lands exactly RD_LAT clocks after the address launch
    if (capCnt_q != '0) begin
      capCnt_d = capCnt_q - CAP_FIRE;
      if (capCnt_q == CAP_FIRE) holdReg_d = ramData;
    end

    unique case (state_q)
      S_IDLE: begin
        serData_d = 1'b0;
        if (enable) begin
          orbSwitch_d = ~orbSwitch_q;
          ramAddr_d   = {orbSwitch_q, {ADDR_W{1'b0}}};
          capCnt_d    = CAP_INIT;
          state_d     = S_PRIME;
        end
      end

      S_PRIME: begin
        if (capCnt_q == CAP_FIRE) begin
          state_d   = S_RUN;
          divCnt_d  = '0;
          bitIdx_d  = '0;
          wordIdx_d = '0;
          stop_d    = 1'b0;
        end
      end

      S_RUN: begin
        divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);
        if (divCnt_q == '0) begin
          if (stop_q && bitIdx_q == '0 && wordIdx_q == '0) begin
            // Last bit period of a stopping frame has just elapsed
            state_d   = S_IDLE;
            serData_d = 1'b0;
            divCnt_d  = '0;
            stop_d    = 1'b0;
          end else begin
            bitStrobe_d = 1'b1;
            if (bitIdx_q == '0) begin
              shiftReg_d   = holdReg_q;
              serData_d    = holdReg_q[DATA_W-1];
              wordStrobe_d = 1'b1;
              frameSync_d  = (wordIdx_q == '0);
              if (wordIdx_q == LAST_WORD) begin
                if (enable) begin
                  orbSwitch_d = ~orbSwitch_q;
                  ramAddr_d   = {orbSwitch_q, {ADDR_W{1'b0}}};
                  capCnt_d    = CAP_INIT;
                end else begin
                  stop_d = 1'b1;
                end
              end else begin
                ramAddr_d = {~orbSwitch_q, wordIdx_q + ADDR_W'(1)};
                capCnt_d  = CAP_INIT;
              end
            end else begin
              shiftReg_d = {shiftReg_q[DATA_W-2:0], 1'b0};
              serData_d  = shiftReg_q[DATA_W-2];
            end

            if (bitIdx_q == BIT_LAST) begin
              bitIdx_d  = '0;
              wordIdx_d = (wordIdx_q == LAST_WORD) ? '0 : wordIdx_q + ADDR_W'(1);
            end else begin
              bitIdx_d = bitIdx_q + BIT_W'(1);
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ramAddr    = ramAddr_q;
  assign orbSwitch  = orbSwitch_q;
  assign serData    = serData_q;
  assign bitStrobe  = bitStrobe_q;
  assign wordStrobe = wordStrobe_q;
  assign frameSync  = frameSync_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_orb_frame_serializer.sv
// Bench for orb_frame_serializer: latency-2 ping-pong RAM model plus a frame-level
// reference that predicts every output cycle from bank contents and enable history.
module tb_orb_frame_serializer;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 2;
  localparam int WORDS   = 4;
  localparam int BIT_DIV = 4;
  localparam int RD_LAT  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] ramData;
  logic [ADDR_W:0]   ramAddr;
  logic              orbSwitch, serData, bitStrobe, wordStrobe, frameSync, busy;

  always #5 clk = ~clk;

  orb_frame_serializer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS),
    .BIT_DIV(BIT_DIV),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ramData   (ramData),
    .ramAddr   (ramAddr),
    .orbSwitch (orbSwitch),
    .serData   (serData),
    .bitStrobe (bitStrobe),
    .wordStrobe(wordStrobe),
    .frameSync (frameSync),
    .busy      (busy)
  );

  // RAM: data for an address launched at edge L is sampled correctly at edge L+2.
  // In glitch mode the data is only right during that single cycle, noise otherwise.
  logic [DATA_W-1:0] mem [2][WORDS];
  logic [ADDR_W:0]   apipe = '0;
  logic [ADDR_W:0]   aprev = '0;
  logic [DATA_W-1:0] noise = 12'h001;
  logic              glitch = 1'b0;

  always @(posedge clk) begin
    apipe <= ramAddr;
    aprev <= apipe;
    noise <= DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
  end

  assign ramData = mem[apipe[ADDR_W]][apipe[ADDR_W-1:0]] ^
                   ((glitch && apipe == aprev) ? noise : '0);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_cyc = 0;
  logic last_cont = 1'b0;
  logic sw_m = 1'b0;
  logic [ADDR_W:0] prev_addr = '0;
  logic [DATA_W-1:0] next_words [WORDS];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output vector order: bitStrobe, wordStrobe, frameSync, serData, busy, orbSwitch
  task automatic expect_outs(input string tag, input logic [5:0] exp);
    check_val(tag, 32'({bitStrobe, wordStrobe, frameSync, serData, busy, orbSwitch}), 32'(exp));
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (ramAddr !== prev_addr) begin
      check_val("prefetch_bank", 32'(ramAddr[ADDR_W]), 32'(!orbSwitch));
      prev_addr = ramAddr;
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < WORDS; w++) next_words[w] = DATA_W'($urandom);
  endtask

  // Called with enable just raised from IDLE; returns on the first bit sample.
  task automatic start_frame();
    logic [ADDR_W:0] exp_addr;
    int n;
    last_cont = 1'b0;
    sw_m = !sw_m;
    step();
    n = 1;
    expect_outs("prime", {4'b0, 1'b1, sw_m});
    exp_addr = {!sw_m, {ADDR_W{1'b0}}};
    check_val("start_addr", 32'(ramAddr), 32'(exp_addr));
    while (!bitStrobe && n < 20) begin
      step();
      n++;
    end
    check_val("start_latency", 32'(n), 32'(RD_LAT + 2));
  endtask

  // Called on the first-bit sample of a frame; returns on the first sample after it.
  task automatic run_frame(input int drop_word);
    logic [DATA_W-1:0] words [WORDS];
    logic [ADDR_W:0]   exp_addr;
    logic              en_last, sd, first;
    if (last_cont)
      check_val("fs_period", 32'(cyc - fs_cyc), 32'(WORDS * DATA_W * BIT_DIV));
    fs_cyc = cyc;
    for (int w = 0; w < WORDS; w++) begin
      words[w] = mem[!sw_m][w];
      mem[sw_m][w] = next_words[w];
    end
    en_last = 1'b1;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < DATA_W; b++) begin
        for (int c = 0; c < BIT_DIV; c++) begin
          if (!(w == 0 && b == 0 && c == 0)) step();
          first = (b == 0 && c == 0);
          if (first && w == WORDS - 1) begin
            en_last = enable;
            if (en_last) sw_m = !sw_m;
          end
          sd = words[w][DATA_W-1-b];
          expect_outs("bit", {(c == 0), first, (first && w == 0), sd, 1'b1, sw_m});
          if (first) begin
            if (w < WORDS - 1)  exp_addr = {!sw_m, ADDR_W'(w + 1)};
            else if (en_last)   exp_addr = {!sw_m, {ADDR_W{1'b0}}};
            else                exp_addr = {!sw_m, ADDR_W'(WORDS - 1)};
            check_val("prefetch_addr", 32'(ramAddr), 32'(exp_addr));
            if (w == drop_word) enable = 1'b0;
          end
        end
      end
    end
    step();
    last_cont = en_last;
    if (!en_last) expect_outs("stop", {5'b0, sw_m});
  endtask

  initial begin
    int k, drop;
    mem[0][0] = 12'hA5C;
    mem[0][1] = 12'h123;
    mem[0][2] = 12'hFFF;
    mem[0][3] = 12'h000;
    for (int w = 0; w < WORDS; w++) mem[1][w] = DATA_W'($urandom);

    repeat (3) @(negedge clk);
    expect_outs("reset", 6'b0);
    check_val("reset_addr", 32'(ramAddr), 32'(0));
    reset = 1'b1;
    prev_addr = ramAddr;
    repeat (2) begin
      step();
      expect_outs("idle", 6'b0);
    end

    enable = 1'b1;
    start_frame();
    next_words[0] = 12'h800;
    next_words[1] = 12'h001;
    next_words[2] = DATA_W'($urandom);
    next_words[3] = DATA_W'($urandom);
    run_frame(-1);
    fill_random();
    run_frame(-1);

    glitch = 1'b1;
    fill_random();
    run_frame(-1);
    fill_random();
    run_frame(1);
    repeat (4) begin
      step();
      expect_outs("idle_hold", {5'b0, sw_m});
    end
    enable = 1'b1;
    start_frame();

    for (int i = 0; i < 4; i++) begin
      fill_random();
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WORDS - 2)) : -1;
      run_frame(drop);
      if (!last_cont) begin
        repeat (3) begin
          step();
          expect_outs("idle_hold", {5'b0, sw_m});
        end
        enable = 1'b1;
        start_frame();
      end
    end

    glitch = 1'b0;
    k = $urandom_range(5, 150);
    repeat (k) step();
    #2 reset = 1'b0;
    #1;
    expect_outs("async_reset", 6'b0);
    check_val("async_reset_addr", 32'(ramAddr), 32'(0));
    prev_addr = ramAddr;
    enable = 1'b0;
    sw_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    expect_outs("post_reset_idle", 6'b0);
    enable = 1'b1;
    start_frame();
    fill_random();
    run_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
